tlb_op_ctrl: RTL and testbench

Sequencer for the TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) in the LoongArch32 core. It sits between the commit stage and the single-ported TLB array. It accepts one operation at a time and drives the array read, search and write ports. It produces the CSR update strobes consumed by the TLBIDX/TLBEHI/TLBELO CSR blocks, and runs INVTLB as a multi-cycle sweep over all entries.

---
 rtl/tlb_pkg.sv | 39 +++
 rtl/tlb_inv_match.sv | 38 +++
 rtl/tlb_op_ctrl.sv | 169 ++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// tlb_pkg: shared definitions for the TLB maintenance sequencer.
//   - opcode / INVTLB op encodings
//   - controller state enum
//   - default geometry and ASID/VPPN field widths
//   - latched INVTLB operand bundle
package tlb_pkg;

  localparam int TLB_ENTRIES_DEF = 64;
  localparam int IDX_W_DEF       = 6;
  localparam int ASID_W          = 10;
  localparam int VPPN_W          = 19;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  localparam logic [4:0] INV_ALL0    = 5'd0;
  localparam logic [4:0] INV_ALL1    = 5'd1;
  localparam logic [4:0] INV_GLB     = 5'd2;
  localparam logic [4:0] INV_NGLB    = 5'd3;
  localparam logic [4:0] INV_ASID    = 5'd4;
  localparam logic [4:0] INV_ASID_VA = 5'd5;
  localparam logic [4:0] INV_GA_VA   = 5'd6;
  localparam logic [4:0] INV_LAST    = INV_GA_VA;

  // INV_ALL is only reachable when the fast clear-all path is built in.
  typedef enum logic [3:0] {
    IDLE, SRCH, SRCH_RSP, RD, RD_RSP, WR, INV_RD, INV_CHK, INV_ALL, DONE
  } state_e;

  typedef struct packed {
    logic [4:0]        op;
    logic [ASID_W-1:0] asid;
    logic [VPPN_W-1:0] vppn;
  } inv_req_t;

endpackage

// File: rtl/tlb_inv_match.sv
// tlb_inv_match: combinational INVTLB match of one TLB entry.
//   inv_op/inv_asid/inv_vppn : INVTLB operands
//   e/g/asid/vppn            : entry fields read from the array
//   match                    : entry must be invalidated
// Illegal inv_op values never match.
module tlb_inv_match
  import tlb_pkg::*;
(
  input  logic [4:0]        inv_op,
  input  logic [ASID_W-1:0] inv_asid,
  input  logic [VPPN_W-1:0] inv_vppn,
  input  logic              e,
  input  logic              g,
  input  logic [ASID_W-1:0] asid,
  input  logic [VPPN_W-1:0] vppn,
  output logic              match
);

  logic asid_eq;
  logic vppn_eq;

  always_comb begin
    asid_eq = (asid == inv_asid);
    vppn_eq = (vppn == inv_vppn);
    match   = 1'b0;
    case (inv_op)
      INV_ALL0,
      INV_ALL1:    match = e;
      INV_GLB:     match = e & g;
      INV_NGLB:    match = e & ~g;
      INV_ASID:    match = e & ~g & asid_eq;
      INV_ASID_VA: match = e & ~g & asid_eq & vppn_eq;
      INV_GA_VA:   match = e & (g | asid_eq) & vppn_eq;
      default:     match = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB between
// commit and the single-ported TLB array.
//   op_valid/op_ready/op_code/inv_*/csr_idx : one-at-a-time request from commit
//   srch_req/srch_hit/srch_idx              : array search port
//   tlb_rd_req/tlb_rd_*                     : array read port (data next cycle)
//   tlb_we/tlb_clr/tlb_idx                  : array write / E-clear port
//   tlbsrch_en/_hit/_hit_idx, tlbrd_en      : CSR update strobes
//   op_done/op_err                          : completion pulse
// Build option: TLB_INV_FAST_EN -- INVTLB op 0/1 becomes a single clear-all
// cycle (tlb_clr with tlb_idx ignored) instead of the entry sweep.
module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter int TLB_ENTRIES = TLB_ENTRIES_DEF,
  parameter int IDX_W       = IDX_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [2:0]        op_code,
  input  logic [4:0]        inv_op,
  input  logic [ASID_W-1:0] inv_asid,
  input  logic [VPPN_W-1:0] inv_vppn,
  input  logic [IDX_W-1:0]  csr_idx,
  output logic              srch_req,
  input  logic              srch_hit,
  input  logic [IDX_W-1:0]  srch_idx,
  output logic              tlb_rd_req,
  input  logic              tlb_rd_e,
  input  logic              tlb_rd_g,
  input  logic [ASID_W-1:0] tlb_rd_asid,
  input  logic [VPPN_W-1:0] tlb_rd_vppn,
  output logic              tlb_we,
  output logic              tlb_clr,
  output logic [IDX_W-1:0]  tlb_idx,
  output logic              tlbsrch_en,
  output logic              tlbsrch_hit,
  output logic [IDX_W-1:0]  tlbsrch_hit_idx,
  output logic              tlbrd_en,
  output logic              op_done,
  output logic              op_err
);

  localparam logic [IDX_W-1:0] SWEEP_LAST = IDX_W'(TLB_ENTRIES - 1);

  state_e           state, state_d;
  logic [IDX_W-1:0] fill_ctr;
  logic [IDX_W-1:0] sweep;
  logic [IDX_W-1:0] idx_q;
  logic             err_q;
  inv_req_t         inv_q;
  logic             srch_en_q;
  logic             srch_hit_q;
  logic [IDX_W-1:0] srch_idx_q;

  logic accept;
  logic inv_legal;
  logic inv_fast;
  logic op_illegal;
  logic ent_match;

  assign accept     = op_valid && (state == IDLE);
  assign inv_legal  = (inv_op <= INV_LAST);
  assign op_illegal = (op_code > OP_INV) || ((op_code == OP_INV) && !inv_legal);

`ifdef TLB_INV_FAST_EN
  assign inv_fast = (inv_op == INV_ALL0) || (inv_op == INV_ALL1);
`else
  assign inv_fast = 1'b0;
`endif

  // Read data arrives in INV_CHK, so the clear decision is made on the live
  // array response in that same cycle.
  tlb_inv_match u_match (
    .inv_op   (inv_q.op),
    .inv_asid (inv_q.asid),
    .inv_vppn (inv_q.vppn),
    .e        (tlb_rd_e),
    .g        (tlb_rd_g),
    .asid     (tlb_rd_asid),
    .vppn     (tlb_rd_vppn),
    .match    (ent_match)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept) begin
        case (op_code)
          OP_SRCH: state_d = SRCH;
          OP_RD:   state_d = RD;
          OP_WR,
          OP_FILL: state_d = WR;
          OP_INV: begin
            if (!inv_legal)    state_d = DONE;
            else if (inv_fast) state_d = INV_ALL;
            else               state_d = INV_RD;
          end
          default: state_d = DONE;
        endcase
      end
      SRCH:     state_d = SRCH_RSP;
      SRCH_RSP: state_d = DONE;
      RD:       state_d = RD_RSP;
      RD_RSP:   state_d = DONE;
      WR:       state_d = DONE;
      INV_RD:   state_d = INV_CHK;
      INV_CHK:  state_d = (sweep == SWEEP_LAST) ? DONE : INV_RD;
      INV_ALL:  state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Operand latch, counters and the registered search result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_ctr   <= '0;
      sweep      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      inv_q      <= '0;
      srch_en_q  <= 1'b0;
      srch_hit_q <= 1'b0;
      srch_idx_q <= '0;
    end else begin
      fill_ctr  <= fill_ctr + 1'b1;
      srch_en_q <= (state == SRCH_RSP);
      if (state == SRCH_RSP) begin
        srch_hit_q <= srch_hit;
        srch_idx_q <= srch_idx;
      end
      if (accept) begin
        // FILL freezes the free-running counter value seen at accept.
        idx_q <= (op_code == OP_FILL) ? fill_ctr : csr_idx;
        err_q <= op_illegal;
        inv_q <= '{op: inv_op, asid: inv_asid, vppn: inv_vppn};
        sweep <= '0;
      end else if ((state == INV_CHK) && (sweep != SWEEP_LAST)) begin
        sweep <= sweep + 1'b1;
      end
    end
  end

  // Output decode
  always_comb begin
    op_ready        = (state == IDLE);
    srch_req        = (state == SRCH);
    tlb_rd_req      = (state == RD) || (state == INV_RD);
    tlb_we          = (state == WR);
    tlb_clr         = ((state == INV_CHK) && ent_match) || (state == INV_ALL);
    tlb_idx         = ((state == INV_RD) || (state == INV_CHK)) ? sweep : idx_q;
    tlbrd_en        = (state == RD_RSP);
    tlbsrch_en      = srch_en_q;
    tlbsrch_hit     = srch_hit_q;
    tlbsrch_hit_idx = srch_idx_q;
    op_done         = (state == DONE);
    op_err          = (state == DONE) && err_q;
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
`timescale 1ns/1ps
module tb_tlb_op_ctrl;
  localparam int N  = 64;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [2:0]    op_code = '0;
  logic [4:0]    inv_op = '0;
  logic [9:0]    inv_asid = '0;
  logic [18:0]   inv_vppn = '0;
  logic [IW-1:0] csr_idx = '0;
  logic          srch_req;
  logic          srch_hit = 1'b0;
  logic [IW-1:0] srch_idx = '0;
  logic          tlb_rd_req;
  logic          tlb_rd_e = 1'b0;
  logic          tlb_rd_g = 1'b0;
  logic [9:0]    tlb_rd_asid = '0;
  logic [18:0]   tlb_rd_vppn = '0;
  logic          tlb_we, tlb_clr;
  logic [IW-1:0] tlb_idx;
  logic          tlbsrch_en, tlbsrch_hit;
  logic [IW-1:0] tlbsrch_hit_idx;
  logic          tlbrd_en, op_done, op_err;

  always #5 clk = ~clk;

  tlb_op_ctrl #(.TLB_ENTRIES(N), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .csr_idx(csr_idx), .srch_req(srch_req), .srch_hit(srch_hit), .srch_idx(srch_idx),
    .tlb_rd_req(tlb_rd_req), .tlb_rd_e(tlb_rd_e), .tlb_rd_g(tlb_rd_g),
    .tlb_rd_asid(tlb_rd_asid), .tlb_rd_vppn(tlb_rd_vppn), .tlb_we(tlb_we),
    .tlb_clr(tlb_clr), .tlb_idx(tlb_idx), .tlbsrch_en(tlbsrch_en),
    .tlbsrch_hit(tlbsrch_hit), .tlbsrch_hit_idx(tlbsrch_hit_idx),
    .tlbrd_en(tlbrd_en), .op_done(op_done), .op_err(op_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Free-running fill counter as seen by the array side: counts clocks since reset.
  logic [IW-1:0] fill_m;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) fill_m <= '0;
    else        fill_m <= fill_m + 1'b1;

  // TLB array: te_m is the reference contents, obs_e what the DUT's clears produced.
  logic [N-1:0] te_m, obs_e, tg;
  logic [9:0]   tasid [N];
  logic [18:0]  tvppn [N];

  localparam logic [9:0]  A0 = 10'h012, A1 = 10'h013;
  localparam logic [18:0] V0 = 19'h01234, V1 = 19'h01235;

  function automatic bit inv_hit(input int j, input logic [4:0] iop,
                                 input logic [9:0] a, input logic [18:0] v);
    bit same_asid = (tasid[j] == a);
    bit same_va   = (tvppn[j] == v);
    if (!te_m[j]) return 1'b0;
    case (iop)
      5'd0, 5'd1: return 1'b1;
      5'd2:       return tg[j];
      5'd3:       return !tg[j];
      5'd4:       return !tg[j] && same_asid;
      5'd5:       return !tg[j] && same_asid && same_va;
      5'd6:       return (tg[j] || same_asid) && same_va;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [8:0] strb();
    return {op_ready, srch_req, tlb_rd_req, tlb_we, tlb_clr,
            tlbsrch_en, tlbrd_en, op_done, op_err};
  endfunction

  task automatic rand_table();
    for (int j = 0; j < N; j++) begin
      te_m[j]  = ($urandom_range(0, 3) != 0);
      tg[j]    = $urandom_range(0, 1);
      tasid[j] = $urandom_range(0, 1) ? A1 : A0;
      tvppn[j] = $urandom_range(0, 1) ? V1 : V0;
    end
    obs_e = te_m;
  endtask

  // One operation: builds the expected per-cycle strobe schedule from the
  // operation rules, then plays the array/search responder while comparing.
  task automatic run_op(input logic [2:0] code, input logic [4:0] iop,
                        input logic [9:0] a, input logic [18:0] v,
                        input logic [IW-1:0] cidx, input logic hit,
                        input logic [IW-1:0] hidx, input int want_fill,
                        input int abort_at);
    logic [8:0] ev[$];
    int ei[$];
    int ej[$];
    logic [IW-1:0] fval;
    logic [8:0] s;
    bit illegal, fast, aborted;
    aborted = 0;
    @(negedge clk);
    for (int w = 0; w < 2*N && want_fill >= 0 && fill_m != want_fill[IW-1:0]; w++)
      @(negedge clk);
    chk("ready_pre", op_ready, 1);
    srch_hit = $urandom; srch_idx = $urandom;
    op_valid = 1'b1; op_code = code; inv_op = iop; inv_asid = a; inv_vppn = v;
    csr_idx = cidx; fval = fill_m;

    illegal = (code > 3'd4) || (code == 3'd4 && iop > 5'd6);
`ifdef TLB_INV_FAST_EN
    fast = (code == 3'd4) && (iop <= 5'd1);
`else
    fast = 0;
`endif
    if (illegal) begin
      ev = {9'h003}; ei = {-1}; ej = {-1};
    end else case (code)
      3'd0: begin ev = {9'h080, 9'h000, 9'h00A}; ei = {-1, -1, -1}; ej = {-1, -1, -1}; end
      3'd1: begin ev = {9'h040, 9'h004, 9'h002}; ei = {int'(cidx), -1, -1}; ej = {-1, -1, -1}; end
      3'd2: begin ev = {9'h020, 9'h002}; ei = {int'(cidx), -1}; ej = {-1, -1}; end
      3'd3: begin ev = {9'h020, 9'h002}; ei = {int'(fval), -1}; ej = {-1, -1}; end
      default: begin
        if (fast) begin
          ev = {9'h010, 9'h002}; ei = {-1, -1}; ej = {-2, -1};
        end else begin
          for (int j = 0; j < N; j++) begin
            bit m = inv_hit(j, iop, a, v);
            ev.push_back(9'h040); ei.push_back(j); ej.push_back(-1);
            ev.push_back(m ? 9'h010 : 9'h000); ei.push_back(m ? j : -1); ej.push_back(m ? j : -1);
          end
          ev.push_back(9'h002); ei.push_back(-1); ej.push_back(-1);
        end
      end
    endcase

    @(posedge clk); #1;
    op_valid = 1'b0;
    op_code = $urandom; inv_op = $urandom; inv_asid = $urandom;
    inv_vppn = $urandom; csr_idx = $urandom;

    for (int k = 0; k < ev.size(); k++) begin
      @(negedge clk);
      s = strb();
      chk($sformatf("op%0d_inv%0d_c%0d_strobes", code, iop, k+1), s, ev[k]);
      if (ei[k] >= 0) chk($sformatf("op%0d_c%0d_idx", code, k+1), tlb_idx, ei[k]);
      if (s[4]) begin
        if (fast) obs_e = '0;
        else      obs_e[tlb_idx] = 1'b0;
      end
      if (ej[k] == -2)     te_m = '0;
      else if (ej[k] >= 0) te_m[ej[k]] = 1'b0;
      if (s[6]) begin
        tlb_rd_e = te_m[tlb_idx]; tlb_rd_g = tg[tlb_idx];
        tlb_rd_asid = tasid[tlb_idx]; tlb_rd_vppn = tvppn[tlb_idx];
      end
      if (s[7]) begin srch_hit = hit; srch_idx = hidx; end
      if (ev[k][1] && code == 3'd0) begin
        chk("srch_hit", tlbsrch_hit, hit);
        chk("srch_hit_idx", tlbsrch_hit_idx, hidx);
      end
      if (abort_at >= 0 && k == 2*abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_strobes", strb(), 9'h100);
        chk("abort_idx", tlb_idx, 0);
        chk("abort_hit", tlbsrch_hit, 0);
        chk("abort_hit_idx", tlbsrch_hit_idx, 0);
        for (int r = 0; r < 3; r++) begin
          @(negedge clk);
          chk("abort_quiet", strb(), 9'h100);
        end
        rst_n = 1'b1;
        aborted = 1;
        break;
      end
    end
    @(negedge clk);
    chk("ready_post", op_ready, 1);
    chk("array", obs_e, te_m);
    if (!aborted) chk("srch_hold", tlbsrch_en, 0);
  endtask

  initial begin
    logic [2:0] c;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_strobes", strb(), 9'h100);
    chk("rst_idx", tlb_idx, 0);
    chk("rst_hit", tlbsrch_hit, 0);
    chk("rst_hit_idx", tlbsrch_hit_idx, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rand_table();

    run_op(3'd0, 0, A0, V0, 0, 1'b1, 6'd17, -1, -1);
    run_op(3'd0, 0, A0, V0, 0, 1'b0, 6'd42, -1, -1);
    run_op(3'd1, 0, A0, V0, 6'd5, 0, 0, -1, -1);
    run_op(3'd2, 0, A0, V0, 6'd40, 0, 0, -1, -1);
    run_op(3'd3, 0, A0, V0, 6'd9, 0, 0, 63, -1);
    run_op(3'd3, 0, A0, V0, 6'd9, 0, 0, -1, -1);

    // INVTLB op 5 against a hand-built table
    te_m = '0; tg = '0;
    for (int j = 0; j < N; j++) begin tasid[j] = A0; tvppn[j] = V0; end
    te_m[3] = 1'b1;
    te_m[9] = 1'b1; tg[9] = 1'b1;
    te_m[20] = 1'b1; tasid[20] = A1;
    obs_e = te_m;
    run_op(3'd4, 5'd5, A0, V0, 0, 0, 0, -1, -1);
    chk("inv5_left", obs_e, 64'h0000_0000_0010_0200);

    run_op(3'd4, 5'd9, A0, V0, 0, 0, 0, -1, -1);
    run_op(3'd6, 0, A0, V0, 0, 0, 0, -1, -1);

    // Reset in the middle of a sweep that would clear everything
    te_m = '1; tg = '1; obs_e = te_m;
    run_op(3'd4, 5'd2, A0, V0, 0, 0, 0, -1, 30);
    chk("abort_left", obs_e, 64'hFFFF_FFFF_C000_0000);

    for (int t = 0; t < 40; t++) begin
      rand_table();
      c = $urandom_range(0, 7);
      run_op(c, 5'($urandom_range(0, 8)), $urandom_range(0, 1) ? A1 : A0,
             $urandom_range(0, 1) ? V1 : V0, 6'($urandom), 1'($urandom),
             6'($urandom), -1, -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
